// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared constants for the AES-128 round-key scheduler.
// State encoding and Rcon constants live here so every file agrees on them.
package aes_key_sched_ctrl_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_LAST   = 2'd2;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

endpackage

// File: rtl/aes_key_sched_ctrl_sbox.sv
// AES forward S-box, purely combinational.
// The table is read byte-wise from a packed constant, entry 0 leftmost.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] w_base;

    assign w_base = {i_byte, 3'b000};
    assign o_byte = SBOX[w_base +: 8];

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 round-key scheduler: one expanded key per rk_next request.
// Keys are produced on the fly from the previous round key and a running Rcon.
module aes_key_sched_ctrl
    import aes_key_sched_ctrl_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [0:127] key_in,
    input  logic         key_load,
    input  logic         rk_next,
    input  logic         rewind,
    output logic [0:127] round_key,
    output logic [3:0]   round_idx,
    output logic         rk_valid,
    output logic         rk_last
);

    localparam logic [3:0] LAST_IDX = 4'(NR);

    logic [1:0]   r_state;
    logic [127:0] r_key;
    logic [127:0] r_rk;
    logic [7:0]   r_rcon;
    logic [3:0]   r_idx;
    logic         r_valid;
    logic         r_last;

    logic [127:0] w_key_in;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [3:0]   w_idx_inc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    // Word 0 occupies the most significant 32 bits internally.
    assign w_key_in = key_in;

    assign w_rot = {r_rk[23:0], r_rk[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte(w_rot[8*g +: 8]),
            .o_byte(w_sub[8*g +: 8])
        );
    end

    assign w_t  = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0 = r_rk[127:96] ^ w_t;
    assign w_n1 = r_rk[95:64]  ^ w_n0;
    assign w_n2 = r_rk[63:32]  ^ w_n1;
    assign w_n3 = r_rk[31:0]   ^ w_n2;

    assign w_idx_inc = r_idx + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_key   <= '0;
            r_rk    <= '0;
            r_rcon  <= RCON_INIT;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (key_load) begin
            r_state <= ST_ACTIVE;
            r_key   <= w_key_in;
            r_rk    <= w_key_in;
            r_rcon  <= RCON_INIT;
            r_idx   <= '0;
            r_valid <= 1'b1;
            r_last  <= 1'b0;
        end else if (rewind && r_state != ST_IDLE) begin
            r_state <= ST_ACTIVE;
            r_rk    <= r_key;
            r_rcon  <= RCON_INIT;
            r_idx   <= '0;
            r_last  <= 1'b0;
        end else if (rk_next && r_state == ST_ACTIVE) begin
            r_rk    <= {w_n0, w_n1, w_n2, w_n3};
            r_rcon  <= xtime(r_rcon);
            r_idx   <= w_idx_inc;
            if (w_idx_inc == LAST_IDX) begin
                r_state <= ST_LAST;
                r_last  <= 1'b1;
            end
        end
    end

    assign round_key = r_rk;
    assign round_idx = r_idx;
    assign rk_valid  = r_valid;
    assign rk_last   = r_last;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl using FIPS-197 key-expansion vectors.
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst;
    logic [0:127] key_in;
    logic         key_load;
    logic         rk_next;
    logic         rewind;
    logic [0:127] round_key;
    logic [3:0]   round_idx;
    logic         rk_valid;
    logic         rk_last;

    int errors = 0;
    int checks = 0;

    logic [127:0] rk_tab [0:10];
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_RK1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;

    aes_key_sched_ctrl #(.NR(10)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .key_load(key_load),
        .rk_next(rk_next), .rewind(rewind), .round_key(round_key),
        .round_idx(round_idx), .rk_valid(rk_valid), .rk_last(rk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; key_load = 0; rk_next = 0; rewind = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic load_a();
        key_in = rk_tab[0]; key_load = 1; tick(); key_load = 0;
    endtask

    task automatic advance(input int n);
        rk_next = 1;
        repeat (n) tick();
        rk_next = 0;
    endtask

    task automatic test_reset();
        key_in = rk_tab[0];
        do_reset();
        checks++;
        if (rk_valid !== 1'b0 || rk_last !== 1'b0 || round_idx !== 4'd0 || round_key !== 128'h0) begin
            errors++;
            $display("FAIL reset: valid=%b last=%b idx=%0d key=%h want 0/0/0/0", rk_valid, rk_last, round_idx, round_key);
        end
        rk_next = 1; rewind = 1; tick(); rk_next = 0; rewind = 0;
        checks++;
        if (rk_valid !== 1'b0 || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL idle_ignore: valid=%b idx=%0d want 0/0", rk_valid, round_idx);
        end
    endtask

    task automatic test_load();
        load_a();
        checks++;
        if (round_key !== rk_tab[0] || round_idx !== 4'd0 || rk_valid !== 1'b1 || rk_last !== 1'b0) begin
            errors++;
            $display("FAIL load: key=%h idx=%0d valid=%b last=%b want %h/0/1/0", round_key, round_idx, rk_valid, rk_last, rk_tab[0]);
        end
        tick(); tick();
        checks++;
        if (round_key !== rk_tab[0] || round_idx !== 4'd0 || rk_valid !== 1'b1) begin
            errors++;
            $display("FAIL hold: key=%h idx=%0d want %h/0", round_key, round_idx, rk_tab[0]);
        end
    endtask

    task automatic test_expand();
        rk_next = 1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (round_key !== rk_tab[i] || round_idx !== 4'(i) || rk_last !== (i == 10) || rk_valid !== 1'b1) begin
                errors++;
                $display("FAIL round%0d: key=%h idx=%0d last=%b want %h/%0d/%b", i, round_key, round_idx, rk_last, rk_tab[i], i, (i == 10));
            end
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (round_key !== rk_tab[10] || round_idx !== 4'd10 || rk_last !== 1'b1) begin
                errors++;
                $display("FAIL last_hold%0d: key=%h idx=%0d last=%b want %h/10/1", i, round_key, round_idx, rk_last, rk_tab[10]);
            end
        end
        rk_next = 0;
    endtask

    task automatic test_rewind();
        rewind = 1; tick(); rewind = 0;
        advance(1);
        checks++;
        if (round_key !== rk_tab[1] || round_idx !== 4'd1 || rk_last !== 1'b0) begin
            errors++;
            $display("FAIL rewind_last: key=%h idx=%0d last=%b want %h/1/0", round_key, round_idx, rk_last, rk_tab[1]);
        end
        advance(4);
        checks++;
        if (round_key !== rk_tab[5] || round_idx !== 4'd5) begin
            errors++;
            $display("FAIL at5: key=%h idx=%0d want %h/5", round_key, round_idx, rk_tab[5]);
        end
        rewind = 1; rk_next = 1; tick(); rewind = 0; rk_next = 0;
        checks++;
        if (round_key !== rk_tab[0] || round_idx !== 4'd0 || rk_valid !== 1'b1) begin
            errors++;
            $display("FAIL rewind5: key=%h idx=%0d want %h/0", round_key, round_idx, rk_tab[0]);
        end
        advance(1);
        checks++;
        if (round_key !== rk_tab[1] || round_idx !== 4'd1) begin
            errors++;
            $display("FAIL replay1: key=%h idx=%0d want %h/1", round_key, round_idx, rk_tab[1]);
        end
    endtask

    task automatic test_priority();
        advance(2);
        key_in = KEY_B; key_load = 1; rk_next = 1; rewind = 1; tick();
        key_load = 0; rewind = 0; rk_next = 0;
        checks++;
        if (round_key !== KEY_B || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL load_over_next: key=%h idx=%0d want %h/0", round_key, round_idx, KEY_B);
        end
        advance(1);
        checks++;
        if (round_key !== KEY_B_RK1 || round_idx !== 4'd1) begin
            errors++;
            $display("FAIL keyb_rk1: key=%h idx=%0d want %h/1", round_key, round_idx, KEY_B_RK1);
        end
        rst = 1; key_in = rk_tab[0]; key_load = 1; tick(); rst = 0; key_load = 0;
        checks++;
        if (rk_valid !== 1'b0 || round_idx !== 4'd0 || round_key !== 128'h0) begin
            errors++;
            $display("FAIL rst_over_load: valid=%b idx=%0d key=%h want 0/0/0", rk_valid, round_idx, round_key);
        end
    endtask

    task automatic test_mid_reset();
        load_a();
        advance(4);
        checks++;
        if (round_key !== rk_tab[4] || round_idx !== 4'd4) begin
            errors++;
            $display("FAIL at4: key=%h idx=%0d want %h/4", round_key, round_idx, rk_tab[4]);
        end
        do_reset();
        rk_next = 1; tick(); rk_next = 0;
        rewind = 1; tick(); rewind = 0;
        advance(2);
        checks++;
        if (rk_valid !== 1'b0 || round_idx !== 4'd0 || round_key !== 128'h0) begin
            errors++;
            $display("FAIL mid_rst: valid=%b idx=%0d key=%h want 0/0/0", rk_valid, round_idx, round_key);
        end
        key_in = KEY_B; key_load = 1; tick(); key_load = 0;
        checks++;
        if (rk_valid !== 1'b1 || round_key !== KEY_B || round_idx !== 4'd0) begin
            errors++;
            $display("FAIL reload: valid=%b key=%h idx=%0d want 1/%h/0", rk_valid, round_key, round_idx, KEY_B);
        end
    endtask

    initial begin
        rk_tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        rk_tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rk_tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rk_tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rk_tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rk_tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rk_tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rk_tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rk_tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rk_tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rk_tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        key_in = '0;
        idle_inputs();
        test_reset();
        test_load();
        test_expand();
        test_rewind();
        test_priority();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
